// File: rtl/serial_work_loader.sv
// Assembles UART bytes into a 256-bit midstate plus 96-bit header tail with inter-byte timeout.
// Optional trailing XOR checksum byte enabled by defining WORK_CHECKSUM_EN.
module serial_work_loader #(
  parameter int unsigned TIMEOUT_CLKS = 500000,
  parameter int unsigned TO_SIZE      = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_new,
  output logic [255:0] midstate,
  output logic [95:0]  data,
  output logic         new_work,
  output logic         frame_err,
  output logic         busy
);

`ifdef WORK_CHECKSUM_EN
  localparam logic [5:0] LastByte = 6'd44;
`else
  localparam logic [5:0] LastByte = 6'd43;
`endif
  localparam logic [TO_SIZE-1:0] ToLast = TO_SIZE'(TIMEOUT_CLKS - 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [TO_SIZE-1:0]   to_q, to_d;
  logic [351:0]         sr_q, sr_d;
  logic [351:0]         sr_shift;
  logic [255:0]         mid_q, mid_d;
  logic [95:0]          dat_q, dat_d;
  logic                 nw_q, nw_d;
  logic                 fe_q, fe_d;
`ifdef WORK_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`else
  // Oldest byte is shifted out on completion and never needed.
  logic                 unused_sr;
  assign unused_sr = ^sr_q[7:0];
`endif

  assign sr_shift = {rx_data, sr_q[351:8]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    sr_d    = sr_q;
    mid_d   = mid_q;
    dat_d   = dat_q;
    nw_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef WORK_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        to_d = '0;
        if (rx_new) begin
          sr_d    = sr_shift;
          cnt_d   = 6'd1;
          state_d = StRecv;
`ifdef WORK_CHECKSUM_EN
          csum_d  = rx_data;
`endif
        end
      end
      StRecv: begin
        if (rx_new) begin
          // A byte arriving on the terminal timeout cycle still counts.
          to_d = '0;
          if (cnt_q == LastByte) begin
`ifdef WORK_CHECKSUM_EN
            if (csum_q == rx_data) begin
              {dat_d, mid_d} = sr_q;
              nw_d           = 1'b1;
            end else begin
              fe_d = 1'b1;
            end
`else
            sr_d           = sr_shift;
            {dat_d, mid_d} = sr_shift;
            nw_d           = 1'b1;
`endif
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + 6'd1;
`ifdef WORK_CHECKSUM_EN
            csum_d = csum_q ^ rx_data;
`endif
          end
        end else if (to_q == ToLast) begin
          fe_d    = 1'b1;
          cnt_d   = '0;
          to_d    = '0;
          state_d = StIdle;
        end else begin
          to_d = to_q + TO_SIZE'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      to_q    <= '0;
      sr_q    <= '0;
      mid_q   <= '0;
      dat_q   <= '0;
      nw_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef WORK_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      sr_q    <= sr_d;
      mid_q   <= mid_d;
      dat_q   <= dat_d;
      nw_q    <= nw_d;
      fe_q    <= fe_d;
`ifdef WORK_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign midstate  = mid_q;
  assign data      = dat_q;
  assign new_work  = nw_q;
  assign frame_err = fe_q;
  assign busy      = (cnt_q != 6'd0);

endmodule

// File: tb/tb_serial_work_loader.sv
// Randomized bench for serial_work_loader: byte-queue reference model checked every cycle.
module tb_serial_work_loader;

  localparam int TO = 200;
`ifdef WORK_CHECKSUM_EN
  localparam int NB = 45;
`else
  localparam int NB = 44;
`endif

  logic         clk;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_new;
  logic [255:0] midstate;
  logic [95:0]  data;
  logic         new_work;
  logic         frame_err;
  logic         busy;

  serial_work_loader #(
    .TIMEOUT_CLKS(TO),
    .TO_SIZE     (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_new   (rx_new),
    .midstate (midstate),
    .data     (data),
    .new_work (new_work),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int nw_cnt   = 0;
  int fe_cnt   = 0;

  // Reference model: bytes of the packet in flight and silent cycles since the last byte.
  logic [7:0]   pkt[$];
  int           idle;
  logic [255:0] m_mid;
  logic [95:0]  m_dat;
  logic         m_nw;
  logic         m_fe;

  task automatic chk(input string nm, input logic [351:0] act, input logic [351:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    logic [7:0] x;
    bit         ok;
    rx_new  = v;
    rx_data = b;
    @(posedge clk);
    m_nw = 1'b0;
    m_fe = 1'b0;
    if (!rst_n) begin
      pkt.delete();
      idle  = 0;
      m_mid = '0;
      m_dat = '0;
    end else if (v) begin
      idle = 0;
      if (pkt.size() == NB - 1) begin
`ifdef WORK_CHECKSUM_EN
        x = 8'h00;
        foreach (pkt[i]) x = x ^ pkt[i];
        ok = (x == b);
`else
        pkt.push_back(b);
        ok = 1'b1;
`endif
        if (ok) begin
          for (int i = 0; i < 32; i++) m_mid[i*8 +: 8] = pkt[i];
          for (int i = 0; i < 12; i++) m_dat[i*8 +: 8] = pkt[32+i];
          m_nw = 1'b1;
        end else begin
          m_fe = 1'b1;
        end
        pkt.delete();
      end else begin
        pkt.push_back(b);
      end
    end else if (pkt.size() != 0) begin
      idle++;
      if (idle == TO) begin
        m_fe = 1'b1;
        pkt.delete();
        idle = 0;
      end
    end
    #1;
    chk("new_work", {351'd0, new_work}, {351'd0, m_nw});
    chk("frame_err", {351'd0, frame_err}, {351'd0, m_fe});
    chk("busy", {351'd0, busy}, {351'd0, pkt.size() != 0});
    chk("midstate", {96'd0, midstate}, {96'd0, m_mid});
    chk("data", {256'd0, data}, {256'd0, m_dat});
    if (new_work) nw_cnt++;
    if (frame_err) fe_cnt++;
    rx_new = 1'b0;
  endtask

  task automatic build(input logic [7:0] pb[44], input bit bad, output logic [7:0] f[NB]);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 44; i++) begin
      f[i] = pb[i];
      x    = x ^ pb[i];
    end
`ifdef WORK_CHECKSUM_EN
    f[44] = x ^ {7'd0, bad};
`else
    if (bad) f[43] = pb[43];
`endif
  endtask

  task automatic send_pkt(input logic [7:0] pb[44], input int gap, input bit bad);
    logic [7:0] f[NB];
    build(pb, bad, f);
    for (int i = 0; i < NB; i++) begin
      step(1'b1, f[i]);
      repeat (gap) step(1'b0, 8'h00);
    end
  endtask

  task automatic rand_pkt(output logic [7:0] pb[44]);
    for (int i = 0; i < 44; i++) pb[i] = 8'($urandom_range(0, 255));
  endtask

  logic [7:0] pb[44];
  logic [7:0] fb[NB];
  int         n0;
  int         f0;

  initial begin
    rst_n   = 1'b1;
    rx_new  = 1'b0;
    rx_data = 8'h00;
    pkt.delete();
    idle  = 0;
    m_mid = '0;
    m_dat = '0;
    #2 rst_n = 1'b0;
    repeat (3) step(1'b0, 8'h00);
    rst_n = 1'b1;
    chk("reset_busy", {351'd0, busy}, 352'd0);
    chk("reset_mid", {96'd0, midstate}, 352'd0);
    step(1'b0, 8'h00);

    // Incrementing packet with wide spacing
    for (int i = 0; i < 44; i++) pb[i] = 8'(i);
    n0 = nw_cnt;
    send_pkt(pb, 99, 1'b0);
    chk("inc_nw_count", 352'(nw_cnt - n0), 352'd1);
    chk("inc_mid_lo", {344'd0, midstate[7:0]}, 352'h00);
    chk("inc_mid_hi", {344'd0, midstate[255:248]}, 352'h1F);
    chk("inc_data_lo", {344'd0, data[7:0]}, 352'h20);
    chk("inc_data_hi", {344'd0, data[95:88]}, 352'h2B);
    chk("inc_busy", {351'd0, busy}, 352'd0);

    // Partial packet abandoned by timeout, then a full packet of 0xA5
    n0 = nw_cnt;
    f0 = fe_cnt;
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom_range(0, 255)));
    repeat (TO) step(1'b0, 8'h00);
    chk("to_fe_count", 352'(fe_cnt - f0), 352'd1);
    chk("to_nw_count", 352'(nw_cnt - n0), 352'd0);
    for (int i = 0; i < 44; i++) pb[i] = 8'hA5;
    send_pkt(pb, 2, 1'b0);
    chk("a5_mid", {96'd0, midstate}, {96'd0, {32{8'hA5}}});
    chk("a5_nw_count", 352'(nw_cnt - n0), 352'd1);

    // Final byte lands exactly on the terminal timeout cycle
    rand_pkt(pb);
    build(pb, 1'b0, fb);
    n0 = nw_cnt;
    f0 = fe_cnt;
    for (int i = 0; i < NB - 1; i++) step(1'b1, fb[i]);
    repeat (TO - 1) step(1'b0, 8'h00);
    step(1'b1, fb[NB-1]);
    chk("edge_new_work", {351'd0, new_work}, 352'd1);
    step(1'b0, 8'h00);
    chk("edge_fe_count", 352'(fe_cnt - f0), 352'd0);
    chk("edge_nw_count", 352'(nw_cnt - n0), 352'd1);

    // Reset in the middle of a packet
    for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom_range(1, 255)));
    rst_n = 1'b0;
    #2;
    chk("rst_async_mid", {96'd0, midstate}, 352'd0);
    chk("rst_async_data", {256'd0, data}, 352'd0);
    chk("rst_async_busy", {351'd0, busy}, 352'd0);
    step(1'b0, 8'h00);
    step(1'b1, 8'h55);
    rst_n = 1'b1;
    rand_pkt(pb);
    send_pkt(pb, 1, 1'b0);
    chk("rst_realign", {96'd0, midstate}, {96'd0, pb[31], pb[30], pb[29], pb[28],
        pb[27], pb[26], pb[25], pb[24], pb[23], pb[22], pb[21], pb[20], pb[19], pb[18],
        pb[17], pb[16], pb[15], pb[14], pb[13], pb[12], pb[11], pb[10], pb[9], pb[8],
        pb[7], pb[6], pb[5], pb[4], pb[3], pb[2], pb[1], pb[0]});

    // Two packets with zero-gap strobes
    n0 = nw_cnt;
    rand_pkt(pb);
    send_pkt(pb, 0, 1'b0);
    rand_pkt(pb);
    send_pkt(pb, 0, 1'b0);
    step(1'b0, 8'h00);
    chk("b2b_nw_count", 352'(nw_cnt - n0), 352'd2);
    chk("b2b_data_hi", {344'd0, data[95:88]}, {344'd0, pb[43]});

`ifdef WORK_CHECKSUM_EN
    for (int i = 0; i < 44; i++) pb[i] = 8'h01;
    n0 = nw_cnt;
    f0 = fe_cnt;
    send_pkt(pb, 1, 1'b0);
    chk("cs_good_nw", 352'(nw_cnt - n0), 352'd1);
    send_pkt(pb, 1, 1'b1);
    chk("cs_bad_fe", 352'(fe_cnt - f0), 352'd1);
    chk("cs_bad_keep", {96'd0, midstate}, {96'd0, {32{8'h01}}});
`endif

    // Random traffic: packets, aborted fragments, occasional bad checksums
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 43)) step(1'b1, 8'($urandom_range(0, 255)));
        repeat (TO + $urandom_range(0, 5)) step(1'b0, 8'h00);
      end else begin
        rand_pkt(pb);
        send_pkt(pb, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      end
    end
    repeat (5) step(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
